// File: rtl/const_fetch_master_if.sv
// const_fetch_master_if
// Bundles the request port, the response port and the APB-style read bus
// of const_fetch_master.
//   master modport : the fetch master (drives req_ready, rsp_*, PSEL,
//                    PENABLE, PWRITE, PRWADDR, PRWDATA)
//   slave modport  : the surrounding environment (requester, response
//                    consumer and the constant-register slave)
// Signals:
//   req_valid/req_sel/req_ready  request handshake (req_sel 0 = pi, 1 = e)
//   rsp_valid/rsp_ready          response handshake
//   rsp_data[63:0]               assembled double, 0 on error
//   rsp_sel/rsp_err              echoed select, timeout flag
//   PSEL/PENABLE/PWRITE          bus control
//   PRWADDR/PRWDATA[31:0]        bus address, write data (always 0)
//   PRWDATA1/PRWDATA2[31:0]      read words, high and low halves
//   PREADY                       slave ready
interface const_fetch_master_if;
  logic        req_valid;
  logic        req_sel;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_sel;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PRWADDR;
  logic [31:0] PRWDATA;
  logic [31:0] PRWDATA1;
  logic [31:0] PRWDATA2;
  logic        PREADY;

  modport master (
    input  req_valid, req_sel, rsp_ready, PRWDATA1, PRWDATA2, PREADY,
    output req_ready, rsp_valid, rsp_data, rsp_sel, rsp_err,
           PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
  );

  modport slave (
    output req_valid, req_sel, rsp_ready, PRWDATA1, PRWDATA2, PREADY,
    input  req_ready, rsp_valid, rsp_data, rsp_sel, rsp_err,
           PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
  );
endinterface

// File: rtl/const_fetch_master.sv
// const_fetch_master
// Read master for the constant-register slave. Accepts one request at a
// time selecting pi or e, performs a single setup/access read, assembles
// {PRWDATA1, PRWDATA2} into a 64-bit double and presents it on a
// valid/ready response port. An access that sees no PREADY within TIMEOUT
// cycles is aborted and reported with rsp_err=1 and rsp_data=0.
// Ports:
//   PCLK    clock, rising edge
//   PRESET  synchronous active-high reset
//   bus     const_fetch_master_if.master (request, response, read bus)
// Parameters:
//   PI_ADDR / E_ADDR  bus addresses of the two constants
//   TIMEOUT           ACCESS cycles allowed before abort (>= 2)
module const_fetch_master #(
  parameter logic [31:0] PI_ADDR = 32'h0000_0004,
  parameter logic [31:0] E_ADDR  = 32'h0000_0008,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  const_fetch_master_if.master  bus
);

  localparam int unsigned       CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]     WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    GAP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] wait_q;
  logic          sel_q;
  logic          err_q;
  logic [31:0]   addr_q;
  logic [63:0]   data_q;

  logic          accept;
  logic          ready_hit;
  logic          timed_out;

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/bus control decoded from the current state
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    ready_hit     = 1'b0;
    timed_out     = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.PSEL      = 1'b0;
    bus.PENABLE   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        bus.PSEL = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        // PREADY takes priority over an expiring wait counter
        if (bus.PREADY) begin
          ready_hit = 1'b1;
          state_d   = RESP;
        end else if (wait_q == WAIT_LAST) begin
          timed_out = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = GAP;
        end
      end
      GAP: begin
        // Dead cycle so the slave's registered PREADY falls before the
        // next SETUP can begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, wait counter and response capture
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sel_q  <= 1'b0;
      addr_q <= '0;
      wait_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        sel_q  <= bus.req_sel;
        addr_q <= bus.req_sel ? E_ADDR : PI_ADDR;
      end

      // Cleared during SETUP so ACCESS always starts counting from 0
      if (state_q == SETUP) begin
        wait_q <= '0;
      end else if (state_q == ACCESS) begin
        wait_q <= wait_q + CW'(1);
      end

      if (ready_hit) begin
        data_q <= {bus.PRWDATA1, bus.PRWDATA2};
        err_q  <= 1'b0;
      end else if (timed_out) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign bus.rsp_data = data_q;
  assign bus.rsp_sel  = sel_q;
  assign bus.rsp_err  = err_q;
  assign bus.PWRITE   = 1'b0;
  assign bus.PRWDATA  = '0;
  assign bus.PRWADDR  = addr_q;

endmodule

// File: doc/const_fetch_master.md
# const_fetch_master

APB-style read master that sits directly upstream of the constant-register slave. It accepts a one-hot-free request selecting π or e, runs one read transaction (setup, then access until PREADY), and assembles the slave's two 32-bit read words into a 64-bit IEEE-754 double. The result goes to a valid/ready response port, with timeout error reporting.

## Interface
- PI_ADDR, 32'h0000_0004, bus address that returns π
- E_ADDR, 32'h0000_0008, bus address that returns e
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (≥2)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_sel  in  1  0 = π, 1 = e
- req_ready  out  1  request accepted when req_valid & req_ready at an edge
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at an edge
- rsp_data  out  64  {PRWDATA1, PRWDATA2} captured; 0 on error
- rsp_sel  out  1  echo of accepted req_sel
- rsp_err  out  1  1 = timeout
- PSEL  out  1  peripheral select
- PENABLE  out  1  access phase
- PWRITE  out  1  constant 0 (reads only)
- PRWADDR  out  32  transaction address
- PRWDATA  out  32  constant 0
- PRWDATA1  in  32  read word, bits 63:32
- PRWDATA2  in  32  read word, bits 31:0
- PREADY  in  1  slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP, GAP.
- IDLE: req_ready=1, PSEL=0, PENABLE=0. On req_valid, latch req_sel and load PRWADDR = req_sel ? E_ADDR : PI_ADDR. Go to SETUP.
- SETUP, one cycle: PSEL=1, PENABLE=0. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. A wait counter starts at 0 on entry and increments each cycle.
  - PREADY=1 at an edge: capture rsp_data={PRWDATA1,PRWDATA2}, rsp_err=0, go to RESP.
  - Otherwise, if counter == TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. Hold rsp_data, rsp_sel and rsp_err stable until rsp_ready. Then go to GAP.
- GAP, one cycle: PSEL=0, lets the slave's registered PREADY return to 0. Then go to IDLE.
- PRWADDR holds its value from SETUP through the end of ACCESS. It stays at its last value otherwise and is never X.
- PREADY is ignored outside ACCESS.
- Only one transaction is outstanding; req_ready=0 in every state except IDLE.

## Timing
- Reset values (next edge with PRESET=1): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_sel=0, rsp_err=0, PSEL=0, PENABLE=0, PWRITE=0, PRWADDR=0, PRWDATA=0, wait counter=0.
- PRESET asserted in any state aborts the transaction: bus outputs drop to 0 on that edge and any pending response is discarded.
- The slave registers both its data and PREADY, so the normal access phase lasts 2 cycles:
  - edge 0: request accepted;
  - cycle 1: SETUP;
  - cycles 2–3: ACCESS, with PREADY sampled high at the end of cycle 3;
  - cycle 4: rsp_valid=1.
- Request-to-rsp_valid latency is 4 cycles when PREADY arrives in the second ACCESS cycle. Each additional PREADY wait cycle adds 1.
- Timeout case: rsp_valid rises exactly TIMEOUT+2 cycles after acceptance.
- With rsp_ready held high, rsp_valid lasts 1 cycle. Minimum spacing between accepted requests is 6 cycles.
- req_valid during RESP/GAP is not accepted. The requester holds it until req_ready.
- PREADY and timeout expiry in the same cycle: PREADY wins, and the response has rsp_err=0 with real data.

## Test plan
- Reset, then req_valid=1, req_sel=0 → PRWADDR=4, PSEL high in cycle 1, PENABLE high in cycles 2–3, rsp_valid in cycle 4 with rsp_data=64'h400921CAC083126F, rsp_sel=0, rsp_err=0.
- req_sel=1 → PRWADDR=8, rsp_data=64'h4005BE76C8B43958, rsp_sel=1.
- rsp_ready held 0 for 5 cycles → rsp_valid and rsp_data stable for all 5 cycles, req_ready=0, PSEL=0; one GAP cycle follows rsp_ready.
- Stub slave with PREADY tied 0 and TIMEOUT=16 → exactly 16 ACCESS cycles, then rsp_valid with rsp_err=1 and rsp_data=0, 18 cycles after acceptance.
- Back-to-back requests (π then e, req_valid held) → second acceptance 6 cycles after the first with rsp_ready=1, PREADY low during GAP, and both responses correct.
- PRESET pulsed during ACCESS → next edge PSEL=PENABLE=0, rsp_valid=0, req_ready=1. A new request then completes normally.
